serial_subtractor: RTL and testbench

- Bit-serial two's-complement subtractor computing DIFF = A − B, LSB first, one bit per clock.
- Uses a single full-subtractor cell plus a registered borrow. It is the inverse-operation counterpart of the team's full-adder cell.
- Sits in the arithmetic library as a low-area datapath element.
- Loads operands in parallel, returns the result in parallel, and uses a start/done handshake.

---
 rtl/serial_subtractor.sv | 138 +++++++++++++
 tb/tb_serial_subtractor.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: DIFF = A - B, one bit per clock, LSB first.
// One full-subtractor cell plus a registered borrow; parallel load, parallel result.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: start is accepted on any edge where the block is not in RUN
  // (IDLE or DONE); done is a one-cycle pulse and results hold until the next done.
  state_t state_q, state_d;

  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;

  logic             cell_x, cell_y, cell_d, cell_b;
  logic [WIDTH-1:0] d_vec, res_shift;
  logic             last_bit, accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Full-subtractor cell on the current LSBs and the registered borrow.
  always_comb begin
    cell_x    = a_sr_q[0];
    cell_y    = b_sr_q[0];
    cell_d    = cell_x ^ cell_y ^ borrow_q;
    cell_b    = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & borrow_q);
    d_vec     = '0;
    d_vec[WIDTH-1] = cell_d;
    res_shift = (res_q >> 1) | d_vec;
    last_bit  = (cnt_q == LAST);
    accept    = start && (state_q != RUN);
  end

  always_comb begin
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    if (accept) begin
      a_sr_d   = a;
      b_sr_d   = b;
      borrow_d = 1'b0;
      cnt_d    = '0;
      a_msb_d  = a[WIDTH-1];
      b_msb_d  = b[WIDTH-1];
    end else if (state_q == RUN) begin
      a_sr_d   = a_sr_q >> 1;
      b_sr_d   = b_sr_q >> 1;
      res_d    = res_shift;
      borrow_d = cell_b;
      cnt_d    = cnt_q + 1'b1;
      // Only the final bit publishes results, so partial sums never reach diff.
      if (last_bit) begin
        diff_d = res_shift;
        bout_d = cell_b;
        ovf_d  = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
      end
    end
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
    diff = diff_q;
    bout = bout_q;
    ovf  = ovf_q;
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, exhaustive WIDTH=3,
// ignored start, back-to-back throughput and asynchronous reset abort.
module tb_serial_subtractor;

  localparam int W  = 8;
  localparam int W3 = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, busy, done, bout, ovf;
  logic [W-1:0]  a, b, diff;
  logic          start3, busy3, done3, bout3, ovf3;
  logic [W3-1:0] a3, b3, diff3;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W+1:0]  exp_q[$];
  logic [W3+1:0] exp3_q[$];

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .ovf(ovf)
  );

  serial_subtractor #(.WIDTH(W3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3),
    .busy(busy3), .done(done3), .diff(diff3), .bout(bout3), .ovf(ovf3)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: {diff, bout, ovf} from plain arithmetic.
  function automatic logic [W+1:0] model8(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    d = x - y;
    return {d, x < y, (x[W-1] != y[W-1]) && (d[W-1] != x[W-1])};
  endfunction

  function automatic logic [W3+1:0] model3(input logic [W3-1:0] x, input logic [W3-1:0] y);
    logic [W3-1:0] d;
    d = x - y;
    return {d, x < y, (x[W3-1] != y[W3-1]) && (d[W3-1] != x[W3-1])};
  endfunction

  // Drivers: called at a negedge, return one negedge after the start edge.
  task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    exp_q.push_back(model8(av, bv));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive_start3(input logic [W3-1:0] av, input logic [W3-1:0] bv);
    a3 = av;
    b3 = bv;
    start3 = 1'b1;
    exp3_q.push_back(model3(av, bv));
    @(negedge clk);
    start3 = 1'b0;
  endtask

  // Bounded wait; cyc=1 means done is already high at the current negedge.
  task automatic wait_done(input int budget, output int cyc, output bit ok);
    cyc = 1;
    ok  = 1'b0;
    while (!ok && cyc <= budget) begin
      if (done === 1'b1) ok = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic wait_done3(input int budget, output int cyc, output bit ok);
    cyc = 1;
    ok  = 1'b0;
    while (!ok && cyc <= budget) begin
      if (done3 === 1'b1) ok = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start3 = 1'b0; a3 = '0; b3 = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, done, diff, bout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL reset8: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy, done, diff, bout, ovf);
    end
    n_tests++;
    if ({busy3, done3, diff3, bout3, ovf3} !== '0) begin
      n_fail++;
      $display("FAIL reset3: got busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy3, done3, diff3, bout3, ovf3);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [W-1:0] va[5] = '{8'h05, 8'h03, 8'h80, 8'h7F, 8'h00};
    logic [W-1:0] vb[5] = '{8'h03, 8'h05, 8'h01, 8'hFF, 8'h00};
    logic [W+1:0] exp, got;
    int cyc, busy_cnt;
    for (int i = 0; i < 5; i++) begin
      drive_start(va[i], vb[i]);
      cyc = 1;
      busy_cnt = 0;
      while (done !== 1'b1 && cyc <= 20) begin
        if (busy === 1'b1) busy_cnt++;
        @(negedge clk);
        cyc++;
      end
      n_tests++;
      if (cyc != 9 || busy_cnt != 8 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL vec%0d_timing: done_cycle=%0d busy_cycles=%0d busy_at_done=%b, want 9/8/0",
                 i, cyc, busy_cnt, busy);
      end
      exp = exp_q.pop_front();
      got = {diff, bout, ovf};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL vec%0d_result a=%h b=%h: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
                 i, va[i], vb[i], got[W+1:2], got[1], got[0], exp[W+1:2], exp[1], exp[0]);
      end
      @(negedge clk);
      n_tests++;
      if (done !== 1'b0 || {diff, bout, ovf} !== exp) begin
        n_fail++;
        $display("FAIL vec%0d_hold: done=%b diff=%h bout=%b ovf=%b, want done=0 and result held",
                 i, done, diff, bout, ovf);
      end
    end
  endtask

  task automatic test_exhaustive3();
    logic [W3+1:0] exp, got;
    int  cyc;
    bit  ok;
    for (int ai = 0; ai < 8; ai++) begin
      for (int bi = 0; bi < 8; bi++) begin
        drive_start3(W3'(ai), W3'(bi));
        wait_done3(10, cyc, ok);
        exp = exp3_q.pop_front();
        got = {diff3, bout3, ovf3};
        n_tests++;
        if (!ok || cyc != 4 || got !== exp) begin
          n_fail++;
          $display("FAIL exh3 a=%0d b=%0d: got %b at cycle %0d (ok=%b), want %b at cycle 4",
                   ai, bi, got, cyc, ok, exp);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    logic [W+1:0] exp;
    int cyc;
    bit ok;
    drive_start(8'h5A, 8'h33);
    repeat (2) @(negedge clk);
    a = 8'hFF;
    b = 8'h01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(20, cyc, ok);
    exp = exp_q.pop_front();
    n_tests++;
    if (!ok || cyc != 6 || {diff, bout, ovf} !== exp) begin
      n_fail++;
      $display("FAIL ignore_start: ok=%b cycle=%0d diff=%h bout=%b ovf=%b, want cycle 6 diff=%h bout=%b ovf=%b",
               ok, cyc, diff, bout, ovf, exp[W+1:2], exp[1], exp[0]);
    end
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_restart: busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] va[3] = '{8'h10, 8'h90, 8'hC8};
    logic [W-1:0] vb[3] = '{8'h20, 8'h10, 8'h64};
    logic [W+1:0] exp;
    int cyc;
    bit ok;
    a = va[0];
    b = vb[0];
    start = 1'b1;
    exp_q.push_back(model8(va[0], vb[0]));
    wait_done(20, cyc, ok);
    for (int i = 1; i <= 3; i++) begin
      exp = exp_q.pop_front();
      n_tests++;
      if (!ok || (i > 1 && cyc != 9) || {diff, bout, ovf} !== exp) begin
        n_fail++;
        $display("FAIL b2b_op%0d: ok=%b gap=%0d diff=%h bout=%b ovf=%b, want gap 9 diff=%h bout=%b ovf=%b",
                 i - 1, ok, cyc, diff, bout, ovf, exp[W+1:2], exp[1], exp[0]);
      end
      if (i < 3) begin
        a = va[i];
        b = vb[i];
        exp_q.push_back(model8(va[i], vb[i]));
        @(negedge clk);
        wait_done(20, cyc, ok);
      end
    end
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_stop: busy=%b done=%b, want 0/0", busy, done);
    end
  endtask

  task automatic test_async_reset();
    logic [W+1:0] exp;
    int cyc;
    bit ok, saw_done;
    drive_start(8'h3C, 8'h0F);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, done, diff, bout, ovf} !== '0) begin
      n_fail++;
      $display("FAIL async_reset_clear: busy=%b done=%b diff=%h bout=%b ovf=%b, want all 0",
               busy, done, diff, bout, ovf);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    n_tests++;
    if (saw_done) begin
      n_fail++;
      $display("FAIL async_reset_abort: got done/busy activity after reset, want none");
    end
    drive_start(8'h3C, 8'h0F);
    wait_done(20, cyc, ok);
    exp = exp_q.pop_front();
    n_tests++;
    if (!ok || cyc != 9 || {diff, bout, ovf} !== exp) begin
      n_fail++;
      $display("FAIL async_reset_recover: ok=%b cycle=%0d diff=%h bout=%b ovf=%b, want cycle 9 diff=%h bout=%b ovf=%b",
               ok, cyc, diff, bout, ovf, exp[W+1:2], exp[1], exp[0]);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_vectors();
    test_exhaustive3();
    test_ignore_start();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
